// File: rtl/secure_reg_pkg.sv
// Shared types and helpers for the secure register arbiter.
// Holds the FSM encoding, the privileged thread ID and counter sizing.
package secure_reg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ACCESS,
    S_RESP,
    S_DENY
  } state_e;

  localparam int TID_PRIV = 0;

  function automatic int cnt_width(input int thresh);
    return $clog2(thresh + 1);
  endfunction

endpackage

// File: rtl/secure_reg_arbiter_if.sv
// Requester bus, response and register-side signals of the arbiter.
// slave is the arbiter view, master is the surrounding environment.
interface secure_reg_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TID_WIDTH  = 8
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ*TID_WIDTH-1:0]  req_tid;
  logic [NUM_REQ-1:0]            gnt;
  logic                          rsp_valid;
  logic                          rsp_err;
  logic [IW-1:0]                 rsp_idx;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic [NUM_REQ-1:0]            quarantined;
  logic                          reg_access_en;
  logic                          reg_wr_en;
  logic [DATA_WIDTH-1:0]         reg_data_in;
  logic [TID_WIDTH-1:0]          reg_thread_id;
  logic [DATA_WIDTH-1:0]         reg_data_out;

  modport slave (
    input  req, req_we, req_wdata, req_tid, reg_data_out,
    output gnt, rsp_valid, rsp_err, rsp_idx, rsp_rdata,
    output quarantined, reg_access_en, reg_wr_en,
    output reg_data_in, reg_thread_id
  );

  modport master (
    output req, req_we, req_wdata, req_tid, reg_data_out,
    input  gnt, rsp_valid, rsp_err, rsp_idx, rsp_rdata,
    input  quarantined, reg_access_en, reg_wr_en,
    input  reg_data_in, reg_thread_id
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick over an eligible mask.
// Search starts at ptr+1 and wraps modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_elig,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_pick,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic w_found;

  always_comb begin
    o_idx   = '0;
    o_pick  = '0;
    w_found = 1'b0;
    o_any   = |i_elig;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (int'(i_ptr) + k) % N;
      if (!w_found && i_elig[j]) begin
        w_found   = 1'b1;
        o_idx     = IW'(j);
        o_pick[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/secure_reg_arbiter.sv
// Shares one secure_register among NUM_REQ requesters with
// round-robin grant, privilege check and violation quarantine.
module secure_reg_arbiter
  import secure_reg_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int TID_WIDTH   = 8,
  parameter int LOCK_THRESH = 3
) (
  input logic clk,
  input logic rst,
  secure_reg_arbiter_if.slave bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = cnt_width(LOCK_THRESH);

  state_e                r_state, w_next;
  logic [IW-1:0]         r_ptr, r_idx;
  logic [NUM_REQ-1:0]    r_gnt;
  logic                  r_we, r_priv;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [TID_WIDTH-1:0]  r_tid;
  logic [CW-1:0]         r_viol [NUM_REQ];
  logic [NUM_REQ-1:0]    r_quar;

  logic [NUM_REQ-1:0]    w_elig, w_pick;
  logic [IW-1:0]         w_idx;
  logic                  w_any;
  logic [TID_WIDTH-1:0]  w_tid;

  assign w_elig = bus.req & ~r_quar;
  assign w_tid  = bus.req_tid[w_idx*TID_WIDTH +: TID_WIDTH];
  assign bus.quarantined = r_quar;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .i_elig (w_elig),
    .i_ptr  (r_ptr),
    .o_pick (w_pick),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  // Denied requests still spend the ACCESS slot (strobes gated)
  // so every response lands three cycles after sampling.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_any) w_next = S_CHECK;
      S_CHECK:  w_next = S_ACCESS;
      S_ACCESS: w_next = r_priv ? S_RESP : S_DENY;
      S_RESP:   w_next = S_IDLE;
      S_DENY:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.gnt           = '0;
    bus.rsp_valid     = 1'b0;
    bus.rsp_err       = 1'b0;
    bus.rsp_idx       = '0;
    bus.rsp_rdata     = '0;
    bus.reg_access_en = 1'b0;
    bus.reg_wr_en     = 1'b0;
    bus.reg_data_in   = '0;
    bus.reg_thread_id = '0;
    unique case (r_state)
      S_CHECK: bus.gnt = r_gnt;
      S_ACCESS: begin
        if (r_priv) begin
          bus.reg_access_en = 1'b1;
          bus.reg_wr_en     = r_we;
          bus.reg_data_in   = r_wdata;
          bus.reg_thread_id = r_tid;
        end
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_idx   = r_idx;
        bus.rsp_rdata = r_we ? '0 : bus.reg_data_out;
      end
      S_DENY: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = 1'b1;
        bus.rsp_idx   = r_idx;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= IW'(NUM_REQ - 1);
      r_idx   <= '0;
      r_gnt   <= '0;
      r_we    <= 1'b0;
      r_priv  <= 1'b0;
      r_wdata <= '0;
      r_tid   <= '0;
      r_quar  <= '0;
      for (int i = 0; i < NUM_REQ; i++) r_viol[i] <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_any) begin
        r_idx   <= w_idx;
        r_ptr   <= w_idx;
        r_gnt   <= w_pick;
        r_we    <= bus.req_we[w_idx];
        r_wdata <= bus.req_wdata[w_idx*DATA_WIDTH +: DATA_WIDTH];
        r_tid   <= w_tid;
        r_priv  <= (w_tid == TID_WIDTH'(TID_PRIV));
      end
      if (r_state == S_RESP && r_we) begin
        r_quar <= '0;
        for (int i = 0; i < NUM_REQ; i++) r_viol[i] <= '0;
      end
      if (r_state == S_DENY) begin
        if (r_viol[r_idx] != CW'(LOCK_THRESH))
          r_viol[r_idx] <= r_viol[r_idx] + 1'b1;
        if (r_viol[r_idx] >= CW'(LOCK_THRESH - 1))
          r_quar[r_idx] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_secure_reg_arbiter.sv
// Directed bench for secure_reg_arbiter with a behavioural
// secure_register model on the register side.
module tb_secure_reg_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] reg_q;
  int n_tests = 0;
  int n_fail  = 0;

  secure_reg_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32), .TID_WIDTH(8)) bus ();

  secure_reg_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(32), .TID_WIDTH(8), .LOCK_THRESH(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) reg_q <= 32'hA5A5_0001;
    else if (bus.reg_access_en && bus.reg_wr_en) reg_q <= bus.reg_data_in;
  end
  assign bus.reg_data_out = reg_q;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic we,
                         input logic [31:0] d, input logic [7:0] tid);
    bus.req_we[i]           = we;
    bus.req_wdata[i*32 +: 32] = d;
    bus.req_tid[i*8 +: 8]   = tid;
    bus.req[i]              = 1'b1;
  endtask

  task automatic run_txn(input int i, input logic we, input logic [31:0] d,
                         input logic [7:0] tid, input logic err,
                         input logic [31:0] rdata);
    set_req(i, we, d, tid);
    tick();
    chk($sformatf("gnt r%0d", i), 64'(bus.gnt), 64'(4'b0001 << i));
    bus.req[i] = 1'b0;
    tick();
    chk($sformatf("strobe r%0d", i), 64'(bus.reg_access_en), 64'(!err));
    if (!err) begin
      chk($sformatf("wr_en r%0d", i), 64'(bus.reg_wr_en), 64'(we));
      if (we) chk($sformatf("wdata r%0d", i), 64'(bus.reg_data_in), 64'(d));
    end
    tick();
    chk($sformatf("rsp_valid r%0d", i), 64'(bus.rsp_valid), 64'd1);
    chk($sformatf("rsp_err r%0d", i), 64'(bus.rsp_err), 64'(err));
    chk($sformatf("rsp_idx r%0d", i), 64'(bus.rsp_idx), 64'(i));
    chk($sformatf("rsp_rdata r%0d", i), 64'(bus.rsp_rdata), 64'(rdata));
    tick();
  endtask

  initial begin
    bus.req       = '0;
    bus.req_we    = '0;
    bus.req_wdata = '0;
    bus.req_tid   = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst gnt", 64'(bus.gnt), 64'd0);
    chk("rst rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst rsp_idx", 64'(bus.rsp_idx), 64'd0);
    chk("rst rdata", 64'(bus.rsp_rdata), 64'd0);
    chk("rst strobe", 64'(bus.reg_access_en), 64'd0);
    chk("rst quar", 64'(bus.quarantined), 64'd0);

    run_txn(2, 1'b0, 32'h0, 8'd0, 1'b0, 32'hA5A5_0001);
    run_txn(0, 1'b1, 32'hDEAD_BEEF, 8'd0, 1'b0, 32'h0);
    run_txn(1, 1'b0, 32'h0, 8'd0, 1'b0, 32'hDEAD_BEEF);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 32'h0, 8'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("rr gnt %0d", k), 64'(bus.gnt), 64'(4'b0001 << (k % 4)));
      tick();
      tick();
      chk($sformatf("rr idx %0d", k), 64'(bus.rsp_idx), 64'(k % 4));
      tick();
    end
    bus.req = '0;
    tick();
    tick();
    tick();
    tick();

    for (int k = 0; k < 3; k++) begin
      run_txn(3, 1'b0, 32'h0, 8'd5, 1'b1, 32'h0);
      chk($sformatf("quar after %0d", k), 64'(bus.quarantined),
          (k == 2) ? 64'h8 : 64'h0);
    end

    set_req(3, 1'b0, 32'h0, 8'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("quar no gnt %0d", k), 64'(bus.gnt), 64'd0);
    end
    run_txn(0, 1'b0, 32'h0, 8'd0, 1'b0, 32'hA5A5_0001);
    run_txn(0, 1'b1, 32'h1234_5678, 8'd0, 1'b0, 32'h0);
    chk("quar cleared", 64'(bus.quarantined), 64'd0);
    tick();
    chk("r3 regranted", 64'(bus.gnt), 64'h8);
    bus.req[3] = 1'b0;
    tick();
    tick();
    chk("r3 rdata", 64'(bus.rsp_rdata), 64'h1234_5678);
    tick();

    set_req(0, 1'b0, 32'h0, 8'd0);
    tick();
    bus.req[0] = 1'b0;
    tick();
    chk("mid strobe", 64'(bus.reg_access_en), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mid strobe off", 64'(bus.reg_access_en), 64'd0);
    chk("mid gnt", 64'(bus.gnt), 64'd0);
    set_req(0, 1'b0, 32'h0, 8'd0);
    set_req(1, 1'b0, 32'h0, 8'd0);
    tick();
    chk("post rst gnt", 64'(bus.gnt), 64'h1);
    bus.req = '0;
    tick();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
